spart_bridge: RTL and testbench

Parametrised host-side bridge between the bus core and one SPART. It drains a TX byte FIFO into the SPART data register and decodes tagged RX bytes ({tag[3:0], payload[3:0]}) into a double-buffered 15-nibble frame. The frame becomes visible atomically on commit, and an explicit acknowledge and overrun detection are provided. It sits between the CPU I/O decode and the SPART `iorw/ioaddr/databus` port.

---
 rtl/spart_bridge.sv | 141 ++++++++++++++
 tb/tb_spart_bridge.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_bridge.sv
// Host-side bridge to one SPART: drains a TX byte FIFO into the data register and
// assembles tagged RX nibbles into a double-buffered 15-nibble frame with commit/ack.
module spart_bridge #(
  parameter int TX_DEPTH = 16,
  parameter int TX_GAP   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      iorw,
  output logic [1:0]                ioaddr,
  inout  wire  [7:0]                databus,
  input  logic                      rda,
  input  logic                      tbr,
  input  logic                      send,
  input  logic [7:0]                data_in,
  output logic                      full,
  output logic [$clog2(TX_DEPTH):0] tx_level,
  input  logic [1:0]                addr,
  output logic [15:0]               data_out,
  input  logic                      rd_ack,
  output logic                      RCV,
  output logic                      ovr
);

  localparam int AW = $clog2(TX_DEPTH);

  typedef enum logic {IDLE, GAP} tx_state_t;

  logic [7:0]    mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, write, read, commit, take;
  tx_state_t     state, state_nx;
  logic [3:0]    gap_cnt, gap_nx;
  logic [3:0]    tag, payload;
  logic [3:0]    stg [0:14];
  logic [3:0]    vis [0:14];

  assign push     = send && !full;
  assign full     = (count == (AW+1)'(TX_DEPTH));
  assign tx_level = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (write) rd_ptr <= rd_ptr + 1'b1;
      case ({push, write})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The SPART write happens in the IDLE cycle that sees a ready transmitter, so a
  // freshly pushed byte goes out in the first cycle after its push edge.
  always_comb begin
    write    = 1'b0;
    state_nx = state;
    gap_nx   = gap_cnt;
    case (state)
      IDLE: begin
        if (count != '0 && tbr && !rda) begin
          write    = 1'b1;
          state_nx = GAP;
          gap_nx   = 4'(TX_GAP - 1);
        end
      end
      GAP: begin
        if (gap_cnt == 4'd0) state_nx = IDLE;
        else                 gap_nx   = gap_cnt - 4'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nx;
      gap_cnt <= gap_nx;
    end
  end

  assign read    = rda && !write;
  assign iorw    = !write;
  assign ioaddr  = (write || read) ? 2'b00 : 2'b01;
  assign databus = write ? mem[rd_ptr] : 8'hzz;

  assign tag     = databus[7:4];
  assign payload = databus[3:0];
  assign commit  = read && (tag == 4'hF);
  assign take    = commit && (!RCV || rd_ack);

  // A commit refused while a frame is still pending leaves both buffers intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        stg[i] <= '0;
        vis[i] <= '0;
      end
      RCV <= 1'b0;
      ovr <= 1'b0;
    end else if (take) begin
      for (int i = 0; i < 15; i++) begin
        vis[i] <= stg[i];
        stg[i] <= '0;
      end
      RCV <= 1'b1;
      ovr <= 1'b0;
    end else begin
      if (read && tag != 4'hF) stg[tag] <= payload;
      if (commit) begin
        ovr <= 1'b1;
      end else if (rd_ack) begin
        RCV <= 1'b0;
        ovr <= 1'b0;
      end
    end
  end

  always_comb begin
    case (addr)
      2'd0:    data_out = {vis[0],  vis[1],  vis[2],  vis[3]};
      2'd1:    data_out = {vis[4],  vis[5],  vis[6],  vis[7]};
      2'd2:    data_out = {vis[8],  vis[9],  vis[10], vis[11]};
      default: data_out = {vis[12], vis[13], vis[14], 4'h0};
    endcase
  end

endmodule

// File: tb/tb_spart_bridge.sv
// Bench for spart_bridge: queue/array model checked every cycle on the falling edge,
// plus directed scenarios with hand-computed literal expectations.
module tb_spart_bridge;

  localparam int TX_DEPTH = 16;
  localparam int TX_GAP   = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        iorw;
  logic [1:0]  ioaddr;
  wire  [7:0]  databus;
  logic        rda, tbr, send, rd_ack;
  logic [7:0]  data_in, rx_byte;
  logic        full;
  logic [4:0]  tx_level;
  logic [1:0]  addr;
  logic [15:0] data_out;
  logic        rcv, ovr;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // the SPART side: drives the bus only while it offers a received byte
  assign databus = rda ? rx_byte : 8'hzz;

  spart_bridge #(.TX_DEPTH(TX_DEPTH), .TX_GAP(TX_GAP)) dut (
    .clk(clk), .rst(rst), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .rda(rda), .tbr(tbr), .send(send), .data_in(data_in), .full(full),
    .tx_level(tx_level), .addr(addr), .data_out(data_out), .rd_ack(rd_ack),
    .RCV(rcv), .ovr(ovr)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mq[$];
  logic [3:0] m_stg [15];
  logic [3:0] m_vis [15];
  bit         m_rcv, m_ovr;
  int         m_last_wr;
  int         wr_cyc[$];
  logic [7:0] wr_byte[$];
  logic [7:0] exp_q[$];

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 15; i++) begin
      m_stg[i] = '0;
      m_vis[i] = '0;
    end
    m_rcv = 0;
    m_ovr = 0;
    m_last_wr = -1000;
  endtask

  function automatic logic [15:0] frame_word(input int a);
    logic [15:0] w = '0;
    for (int i = 0; i < 4; i++) begin
      int idx = a * 4 + i;
      w = {w[11:0], (idx < 15) ? m_vis[idx] : 4'h0};
    end
    return w;
  endfunction

  // compare process: outputs are stable mid-cycle, inputs change just after posedge
  always @(negedge clk) begin
    bit exp_wr;
    bit was_full;
    if (rst) begin
      model_reset();
      exp_wr = 0;
    end else begin
      exp_wr = (mq.size() > 0) && tbr && !rda && (cyc - m_last_wr > TX_GAP);
    end
    chk("iorw", 32'(iorw), 32'(!exp_wr));
    chk("ioaddr", 32'(ioaddr), (exp_wr || rda) ? 32'd0 : 32'd1);
    if (exp_wr) chk("databus", 32'(databus), 32'(mq[0]));
    chk("full", 32'(full), 32'(mq.size() == TX_DEPTH));
    chk("tx_level", 32'(tx_level), 32'(mq.size()));
    chk("rcv", 32'(rcv), 32'(m_rcv));
    chk("ovr", 32'(ovr), 32'(m_ovr));
    chk("data_out", 32'(data_out), 32'(frame_word(int'(addr))));
    if (!iorw) begin
      wr_cyc.push_back(cyc);
      wr_byte.push_back(databus);
    end
    if (!rst) begin
      was_full = (mq.size() >= TX_DEPTH);
      if (exp_wr) begin
        void'(mq.pop_front());
        m_last_wr = cyc;
      end
      if (send && !was_full) mq.push_back(data_in);
      if (rda && rx_byte[7:4] != 4'hF) begin
        m_stg[rx_byte[7:4]] = rx_byte[3:0];
        if (rd_ack) begin
          m_rcv = 0;
          m_ovr = 0;
        end
      end else if (rda && (!m_rcv || rd_ack)) begin
        for (int i = 0; i < 15; i++) begin
          m_vis[i] = m_stg[i];
          m_stg[i] = '0;
        end
        m_rcv = 1;
        m_ovr = 0;
      end else if (rda) begin
        m_ovr = 1;
      end else if (rd_ack) begin
        m_rcv = 0;
        m_ovr = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic ack);
    rda = 1'b1;
    rx_byte = b;
    rd_ack = ack;
    tick();
    rda = 1'b0;
    rd_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int k, n0, m;
    rst = 1'b1; rda = 1'b0; tbr = 1'b0; send = 1'b0; rd_ack = 1'b0;
    data_in = '0; rx_byte = '0; addr = 2'd0;
    repeat (3) tick();
    chk("rst_iorw", 32'(iorw), 32'd1);
    chk("rst_ioaddr", 32'(ioaddr), 32'd1);
    chk("rst_level", 32'(tx_level), 32'd0);
    chk("rst_rcv", 32'(rcv), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'h0);
    rst = 1'b0;
    tick();

    // TX drain, three bytes back to back
    tbr = 1'b1;
    n0 = wr_cyc.size();
    send = 1'b1; data_in = 8'h41; tick(); k = cyc;
    data_in = 8'h42; tick();
    data_in = 8'h43; tick();
    send = 1'b0;
    repeat (8) tick();
    chk("drain_count", 32'(wr_cyc.size() - n0), 32'd3);
    if (wr_cyc.size() - n0 == 3) begin
      chk("drain_b0", 32'(wr_byte[n0]),   32'h41);
      chk("drain_b1", 32'(wr_byte[n0+1]), 32'h42);
      chk("drain_b2", 32'(wr_byte[n0+2]), 32'h43);
      chk("drain_c0", 32'(wr_cyc[n0]   - k), 32'd0);
      chk("drain_c1", 32'(wr_cyc[n0+1] - k), 32'd2);
      chk("drain_c2", 32'(wr_cyc[n0+2] - k), 32'd4);
    end
    chk("drain_level", 32'(tx_level), 32'd0);

    // TX full: 17 pushes with the transmitter busy
    tbr = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      send = 1'b1; data_in = 8'(i);
      tick();
      if (i == 16) chk("full_after_16", 32'(full), 32'd1);
      if (i <= 16) exp_q.push_back(8'(i));
    end
    send = 1'b0;
    chk("full_level", 32'(tx_level), 32'd16);
    tbr = 1'b1;
    n0 = wr_cyc.size();
    repeat (40) tick();
    chk("full_drain_count", 32'(wr_cyc.size() - n0), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (n0 + i < wr_byte.size() && exp_q.size() > 0)
        chk("full_drain_byte", 32'(wr_byte[n0+i]), 32'(exp_q.pop_front()));
    end
    chk("full_cleared", 32'(full), 32'd0);

    // frame commit
    rx_send(8'h0A, 1'b0); rx_send(8'h1B, 1'b0); rx_send(8'h2C, 1'b0);
    rx_send(8'h3D, 1'b0); rx_send(8'hEF, 1'b0); rx_send(8'hF0, 1'b0);
    chk("commit_rcv", 32'(rcv), 32'd1);
    addr = 2'd0; #1;
    chk("commit_w0", 32'(data_out), 32'hABCD);
    chk("model_w0", 32'(frame_word(0)), 32'hABCD);
    addr = 2'd3; #1;
    chk("commit_w3", 32'(data_out), 32'h00F0);
    chk("model_w3", 32'(frame_word(3)), 32'h00F0);
    addr = 2'd1; #1;
    chk("commit_w1", 32'(data_out), 32'h0000);

    // overrun, then acknowledge together with a third commit
    rx_send(8'h05, 1'b0); rx_send(8'h16, 1'b0); rx_send(8'hF0, 1'b0);
    addr = 2'd0; #1;
    chk("ovr_set", 32'(ovr), 32'd1);
    chk("ovr_rcv", 32'(rcv), 32'd1);
    chk("ovr_w0_kept", 32'(data_out), 32'hABCD);
    rx_send(8'h27, 1'b0);
    rx_send(8'hF0, 1'b1);
    chk("ack_commit_rcv", 32'(rcv), 32'd1);
    chk("ack_commit_ovr", 32'(ovr), 32'd0);
    chk("ack_commit_w0", 32'(data_out), 32'h5670);
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    chk("ack_clear_rcv", 32'(rcv), 32'd0);

    // arbitration: rda holds off the write
    repeat (3) tick();
    n0 = wr_cyc.size();
    rda = 1'b1; rx_byte = 8'h31; send = 1'b1; data_in = 8'h55;
    tick();
    send = 1'b0;
    repeat (3) tick();
    chk("arb_blocked", 32'(wr_cyc.size() - n0), 32'd0);
    rda = 1'b0; m = cyc;
    repeat (3) tick();
    chk("arb_count", 32'(wr_cyc.size() - n0), 32'd1);
    if (wr_cyc.size() - n0 == 1) begin
      chk("arb_cycle", 32'(wr_cyc[n0] - m), 32'd0);
      chk("arb_byte", 32'(wr_byte[n0]), 32'h55);
    end

    // reset asserted in the middle of a write cycle
    repeat (3) tick();
    send = 1'b1; data_in = 8'h99; tick(); send = 1'b0;
    #1;
    chk("midrst_writing", 32'(iorw), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_iorw", 32'(iorw), 32'd1);
    chk("midrst_ioaddr", 32'(ioaddr), 32'd1);
    chk("midrst_level", 32'(tx_level), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    n0 = wr_cyc.size();
    repeat (5) tick();
    chk("midrst_lost", 32'(wr_cyc.size() - n0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
